// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if: start/done handshake and operand/result bus of the Booth multiplier.
// Latency: n/a (wires only).
// Backpressure: none; the master may raise start at any time and the slave ignores it while busy.
// Ports (signals): start, multiplicand, multiplier (master -> slave);
//                  busy, done, product (slave -> master).
interface booth_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier: multi-cycle signed (two's-complement) Booth multiplier with integrated controller.
// Latency: WIDTH RUN cycles (WE/2 with radix-4), done pulses in the cycle after the last iteration.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Optional feature macro: BOOTH_RADIX4_EN selects radix-4 (modified) Booth recoding, retiring
// two multiplier bits per cycle. Without it only the radix-2 datapath is built.
//
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low clear of all state and outputs
//   bus    slave side of booth_multiplier_if:
//            start, multiplicand (M), multiplier (Q) in; busy, done, product out.
// WIDTH legal range is 2..32; the interface instance must use the same WIDTH.
module booth_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   booth_multiplier_if.slave bus
);

`ifdef BOOTH_RADIX4_EN
   // Multiplier is sign-extended to an even width so it splits into whole bit pairs.
   localparam int WE = WIDTH + (WIDTH % 2);
   // Two guard bits: +/-2M must fit alongside the running accumulator.
   localparam int AW = WIDTH + 2;
   localparam int SH = 2;
`else
   localparam int WE = WIDTH;
   // One guard bit so A-M cannot overflow when M is the most negative value.
   localparam int AW = WIDTH + 1;
   localparam int SH = 1;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] ITERS = CW'(WE / SH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic signed [AW-1:0] a_q;
   logic signed [AW-1:0] m_q;
   logic [WE-1:0]        q_q;
   logic                 q1_q;
   logic [CW-1:0]        count_q;
   logic [PW-1:0]        product_q;

   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] a_d;
   logic [WE-1:0]        q_d;
   logic                 q1_d;

   // One Booth iteration: recode the low multiplier bits, add the selected multiple of M,
   // then shift {A,Q,Q_1} arithmetically right by the number of bits retired.
   always_comb begin
      sum = a_q;
`ifdef BOOTH_RADIX4_EN
      case ({q_q[1], q_q[0], q1_q})
         3'b001, 3'b010: sum = a_q + m_q;
         3'b011:         sum = a_q + (m_q <<< 1);
         3'b100:         sum = a_q - (m_q <<< 1);
         3'b101, 3'b110: sum = a_q - m_q;
         default:        sum = a_q;
      endcase
`else
      case ({q_q[0], q1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
`endif
      // A keeps its sign on the shift; the bits falling out of A enter the top of Q,
      // and the last bit shifted out of Q becomes the new Q_1.
      a_d  = sum >>> SH;
      q_d  = WE'({sum[SH-1:0], q_q} >> SH);
      q1_d = q_q[SH-1];
   end

   // Controller and datapath registers. DONE accepts a new start directly so a held start
   // gives back-to-back operation with one result every ITERS+1 cycles.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_q     <= '0;
                  m_q     <= AW'($signed(bus.multiplicand));
                  q_q     <= WE'($signed(bus.multiplier));
                  q1_q    <= 1'b0;
                  count_q <= ITERS;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_d;
               q_q     <= q_d;
               q1_q    <= q1_d;
               count_q <= count_q - CW'(1);
               // Last iteration: the shifted {A,Q} already holds the full product;
               // the guard bits above 2*WIDTH are pure sign copies and are dropped.
               if (count_q == CW'(1)) begin
                  product_q <= PW'({a_d, q_d});
                  state_q   <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Decoded straight from the state register, so neither output can glitch.
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: checks booth_multiplier at WIDTH=8 and WIDTH=7 against a cycle-level
// behavioural model (countdown + plain signed multiply), plus hand-computed directed results.
// Inputs are driven on the falling edge and outputs are compared on the falling edge.
module tb_booth_multiplier;

`ifdef BOOTH_RADIX4_EN
   localparam int LAT8 = 4;
   localparam int LAT7 = 4;
`else
   localparam int LAT8 = 8;
   localparam int LAT7 = 7;
`endif

   logic clk   = 1'b0;
   logic clr_n = 1'b1;
   bit   chk_en = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   booth_multiplier_if #(.WIDTH(8)) bus8();
   booth_multiplier_if #(.WIDTH(7)) bus7();

   booth_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .clr_n(clr_n), .bus(bus8));
   booth_multiplier #(.WIDTH(7)) dut7 (.clk(clk), .clr_n(clr_n), .bus(bus7));

   // Model state: cycles of RUN left, done flag, delivered product, product in flight.
   typedef struct {
      int     left;
      bit     dn;
      longint prod;
      longint pend;
   } mstate_t;

   mstate_t s8 = '{0, 1'b0, 0, 0};
   mstate_t s7 = '{0, 1'b0, 0, 0};

   function automatic void step(inout mstate_t s, input bit st, input longint a,
                                input longint b, input int lat, input int w);
      longint mask = (longint'(1) << (2 * w)) - 1;
      s.dn = (s.left == 1);
      if (s.left == 1) s.prod = s.pend;
      if (s.left > 0) begin
         s.left--;
      end else if (st) begin
         s.left = lat;
         s.pend = (a * b) & mask;
      end
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model, advanced on every active clock edge and cleared by reset.
   initial forever begin
      @(posedge clk or negedge clr_n);
      if (!clr_n) begin
         s8 = '{0, 1'b0, 0, 0};
         s7 = '{0, 1'b0, 0, 0};
      end else begin
         step(s8, bus8.start, longint'($signed(bus8.multiplicand)),
              longint'($signed(bus8.multiplier)), LAT8, 8);
         step(s7, bus7.start, longint'($signed(bus7.multiplicand)),
              longint'($signed(bus7.multiplier)), LAT7, 7);
      end
   end

   // Compare process: every cycle, both DUTs against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("busy8", bus8.busy, longint'(s8.left > 0));
         check("done8", bus8.done, longint'(s8.dn));
         check("prod8", bus8.product, s8.prod);
         check("busy7", bus7.busy, longint'(s7.left > 0));
         check("done7", bus7.done, longint'(s7.dn));
         check("prod7", bus7.product, s7.prod);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   // Single operation on the 8-bit DUT; called and returns on a falling edge.
   task automatic op8(input int a, input int b, input longint exp, input string nm);
      int busy_n = 0;
      bit seen   = 1'b0;
      bus8.start        = 1'b1;
      bus8.multiplicand = 8'(a);
      bus8.multiplier   = 8'(b);
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus8.done) begin
            seen = 1'b1;
         end else begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
         end
      end
      check({"done_", nm}, longint'(seen), 1);
      check({"lat_", nm}, busy_n, LAT8);
      check({"prod_", nm}, bus8.product, exp);
      check({"model_", nm}, s8.prod, exp);
      @(negedge clk);
      check({"pulse_", nm}, bus8.done, 0);
   endtask

   initial begin
      int c;
      bit seen;
      int n8;
      int n7;
      int cyc;

      bus8.start = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;
      bus7.start = 1'b0; bus7.multiplicand = '0; bus7.multiplier = '0;

      // Reset state.
      #2 clr_n = 1'b0;
      #1;
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_prod", bus8.product, 0);
      check("rst_prod7", bus7.product, 0);
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // Directed products (hand-computed).
      op8(3, 5, 'h000F, "3x5");
      op8(-7, 6, 'hFFD6, "m7x6");
      op8(-128, -128, 'h4000, "minxmin");
      op8(127, -128, 'hC080, "maxxmin");
      op8(0, 0, 'h0000, "0x0");
      op8(0, -5, 'h0000, "0xm5");
      op8(-1, -1, 'h0001, "m1xm1");

      // Start held across completions: DONE goes straight back to RUN.
      bus8.start = 1'b1; bus8.multiplicand = 8'd3; bus8.multiplier = 8'd5;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus8.done) seen = 1'b1;
      end
      check("b2b_first_done", longint'(seen), 1);
      check("b2b_first_prod", bus8.product, 'h000F);
      bus8.multiplicand = 8'hFE; bus8.multiplier = 8'hFE;
      c = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         c++;
         if (bus8.done) seen = 1'b1;
      end
      check("b2b_gap", c, LAT8 + 1);
      check("b2b_second_prod", bus8.product, 'h0004);
      bus8.start = 1'b0;
      @(negedge clk);
      check("b2b_idle", bus8.busy, 0);

      // Start and operand changes during RUN are ignored.
      bus8.start = 1'b1; bus8.multiplicand = 8'd3; bus8.multiplier = 8'd5;
      c = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         c++;
         if (c == 1) bus8.start = 1'b0;
         if (c == 3) begin
            bus8.start = 1'b1; bus8.multiplicand = 8'd100; bus8.multiplier = 8'hFD;
         end
         if (c == 4) begin
            bus8.start = 1'b0; bus8.multiplicand = 8'hFF;
         end
         if (bus8.done) seen = 1'b1;
      end
      check("run_ign_lat", c, LAT8 + 1);
      check("run_ign_prod", bus8.product, 'h000F);
      @(negedge clk);

      // Reset in the 4th RUN cycle abandons the operation immediately.
      bus8.start = 1'b1; bus8.multiplicand = 8'd3; bus8.multiplier = 8'd5;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      check("midrst_busy", bus8.busy, 0);
      check("midrst_done", bus8.done, 0);
      check("midrst_prod", bus8.product, 0);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      op8(2, 2, 'h0004, "2x2_after_rst");

      // Randomised operands on both widths, start asserted at random (also during RUN).
      n8 = 0; n7 = 0; cyc = 0;
      while ((n8 < 1000 || n7 < 1000) && cyc < 40000) begin
         bus8.start        = ($urandom_range(0, 3) != 0);
         bus8.multiplicand = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         bus8.multiplier   = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         bus7.start        = ($urandom_range(0, 3) != 0);
         bus7.multiplicand = ($urandom_range(0, 7) == 0) ? 7'h40 : 7'($urandom);
         bus7.multiplier   = ($urandom_range(0, 7) == 0) ? 7'h40 : 7'($urandom);
         @(negedge clk);
         cyc++;
         if (bus8.done) n8++;
         if (bus7.done) n7++;
      end
      check("rand_count8", longint'(n8 >= 1000), 1);
      check("rand_count7", longint'(n7 >= 1000), 1);
      bus8.start = 1'b0;
      bus7.start = 1'b0;
      repeat (LAT8 + 3) @(negedge clk);
      check("drain_busy8", bus8.busy, 0);
      check("drain_busy7", bus7.busy, 0);

      // 7-bit corner: most negative squared.
      bus7.start = 1'b1; bus7.multiplicand = 7'h40; bus7.multiplier = 7'h40;
      c = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         c++;
         bus7.start = 1'b0;
         if (bus7.done) seen = 1'b1;
      end
      check("w7_lat", c, LAT7 + 1);
      check("w7_prod", bus7.product, 'h1000);
      @(negedge clk);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Self-contained signed Booth multiplier: parametrised datapath plus an integrated controller FSM, so no external sequencer is needed.
- Computes the two's-complement product of two WIDTH-bit operands using a start/done handshake.
- Intended as the drop-in arithmetic unit wherever a multi-cycle signed multiply is needed, in place of a hand-wired data path and controller pair.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset; clears all state.
- start  input  1  request; sampled on clk in IDLE or DONE.
- multiplicand  input  WIDTH  signed operand M; captured on accepted start.
- multiplier  input  WIDTH  signed operand Q; captured on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse, high while state is DONE.
- product  output  2*WIDTH  signed result; holds its value until the next completion.

Behaviour:
- One clock; reset is asynchronous and active-low (clr_n). While clr_n=0:
  - state=IDLE; busy=0, done=0, product=0.
  - Internal A, Q, Q_1, M and count are all cleared.
- Operands are captured at acceptance; input changes afterwards have no effect.
- Internal registers:
  - A: WIDTH+1 bits, signed accumulator. The extra bit avoids overflow on A-M when M is the most negative value.
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - count: $clog2(WIDTH+1) bits.
- FSM states:
  - IDLE: start=1 -> load A=0, Q=multiplier, Q_1=0, M=sext(multiplicand), count=WIDTH; go to RUN.
  - RUN: one iteration per cycle.
    - Select on {Q[0],Q_1}: 01 -> A+M; 10 -> A-M; 00/11 -> A.
    - Arithmetic right-shift {A',Q,Q_1} by 1; the MSB of A is replicated.
    - count decrements by 1.
    - On the iteration where count==1: product <= {A,Q}[2*WIDTH-1:0] after the shift; go to DONE.
  - DONE: lasts exactly one cycle.
    - start=1 -> accept new operands as in IDLE and go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- busy and done are decoded directly from registered state, so both are glitch-free.
- Latency: start accepted at edge E0; done is high during the cycle following edge E(WIDTH); product is valid from that same edge.
- Throughput: one result every WIDTH+1 cycles when start is held high.
- start while in RUN: ignored. No queueing, no effect on the operation in flight.
- Reset asserted mid-operation: the operation is abandoned and all outputs return to their reset values immediately.
- Corner cases:
  - Zero operands follow the normal latency.
  - Most-negative x most-negative gives the correct positive result; 2*WIDTH bits are always sufficient.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined: radix-4 (modified) Booth.
  - The multiplier is sign-extended to an even width WE = WIDTH rounded up to even.
  - Each RUN cycle examines {Q[1],Q[0],Q_1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - {A,Q,Q_1} is then shifted arithmetically right by 2.
  - A widens to WIDTH+2 bits.
  - count loads WE/2; latency becomes WE/2 cycles (4 for WIDTH=8).
  - Results must be bit-identical to radix-2.
- Undefined: radix-2 only, as described in Behaviour; no radix-4 logic is synthesised.

Test Plan:
- WIDTH=8, M=3, Q=5, start pulse -> busy for 8 cycles; done pulse on the 9th cycle after acceptance; product=0x000F.
- M=-7, Q=6 -> product=0xFFD6 (-42); M=-128, Q=-128 -> product=0x4000; M=127, Q=-128 -> product=0xC080.
- Start held high across completions with operand pairs (3,5) then (-2,-2) -> DONE goes directly to RUN; done pulses 9 cycles apart; products 0x000F then 0x0004.
- During RUN, pulse start with different operands and change the inputs -> no effect; the original result is delivered on schedule.
- Assert clr_n low at the 4th RUN cycle -> busy=0, done=0, product=0 immediately; after release, a new start (2x2) gives 0x0004.
- With BOOTH_RADIX4_EN, randomised 1000 operand pairs at WIDTH=8 and WIDTH=7 -> product equals the signed reference model; latency 4 cycles for both widths.
